// File: rtl/sdram_upload_reader.sv
`default_nettype none
// ============================================================================
// sdram_upload_reader : returns upload bytes from SDRAM (index 0/1) or CMOS
// (index 8'hFF) to data_io.  Option UPLOAD_PREFETCH_EN: sequential prefetch.
// Rev 1.0
// ============================================================================
module sdram_upload_reader #(
  parameter int            AW         = 25,
  parameter logic [AW-1:0] ROM_BASE   = 25'h080000,
  parameter logic [AW-1:0] SWRAM_BASE = 25'h040000
) (
  input  logic          clk_48m,
  input  logic          reset,
  input  logic          mem_sync,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  input  logic [7:0]    cmos_din,
  output logic          mem_req,
  output logic [AW-1:0] mem_adr,
  input  logic [7:0]    mem_data,
  output logic          busy,
  output logic          rd_miss
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t        state;
  logic          rd_req, fetch_idx, next_req;
  logic          upload_d, abort, pend_valid;
  logic [AW-1:0] base, req_adr, next_adr, pend_adr;

`ifdef UPLOAD_PREFETCH_EN
  logic          pf_run, pf_valid;
  logic [AW-1:0] pf_tag;
  logic [7:0]    pf_data;
`endif

  always_comb begin
    fetch_idx = (ioctl_index == 8'h00) || (ioctl_index == 8'h01);
    base      = (ioctl_index == 8'h01) ? SWRAM_BASE : ROM_BASE;
    req_adr   = base + AW'(ioctl_addr);
    rd_req    = ioctl_rd & ioctl_upload;
    // A read landing on the completing slot is the newest request and wins.
    next_req  = (rd_req & fetch_idx) | pend_valid;
    next_adr  = (rd_req & fetch_idx) ? req_adr : pend_adr;
  end

  always_ff @(posedge clk_48m) begin
    if (reset) begin
      state      <= IDLE;
      ioctl_din  <= 8'hFF;
      mem_req    <= 1'b0;
      mem_adr    <= '0;
      busy       <= 1'b0;
      rd_miss    <= 1'b0;
      upload_d   <= 1'b0;
      abort      <= 1'b0;
      pend_valid <= 1'b0;
      pend_adr   <= '0;
`ifdef UPLOAD_PREFETCH_EN
      pf_run     <= 1'b0;
      pf_valid   <= 1'b0;
      pf_tag     <= '0;
      pf_data    <= 8'hFF;
`endif
    end else begin
      upload_d <= ioctl_upload;
      if (ioctl_upload && !upload_d) rd_miss <= 1'b0;

      if (busy && rd_req) begin
`ifdef UPLOAD_PREFETCH_EN
        if (!pf_run) rd_miss <= 1'b1;
`else
        rd_miss <= 1'b1;
`endif
        if (fetch_idx) begin
          pend_valid <= 1'b1;
          pend_adr   <= req_adr;
        end
      end

      if (!ioctl_upload) begin
        pend_valid <= 1'b0;
`ifdef UPLOAD_PREFETCH_EN
        pf_valid   <= 1'b0;
`endif
      end

      case (state)
        IDLE: begin
          if (rd_req) begin
            if (ioctl_index == 8'hFF) begin
              ioctl_din <= cmos_din;
            end else if (fetch_idx) begin
              state   <= WAIT_SLOT;
              mem_req <= 1'b1;
              busy    <= 1'b1;
              abort   <= 1'b0;
`ifdef UPLOAD_PREFETCH_EN
              pf_valid <= 1'b0;
              if (pf_valid && (req_adr == pf_tag)) begin
                ioctl_din <= pf_data;
                mem_adr   <= pf_tag + AW'(1);
                pf_run    <= 1'b1;
              end else begin
                mem_adr   <= req_adr;
                pf_run    <= 1'b0;
              end
`else
              mem_adr <= req_adr;
`endif
            end else begin
              ioctl_din <= 8'hFF;
            end
          end
        end

        WAIT_SLOT: begin
          // The slot is not claimed yet, so an ended upload can drop out at once.
          if (!ioctl_upload) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
          end else if (mem_sync) begin
            state <= WAIT_DATA;
          end
        end

        WAIT_DATA: begin
          if (!ioctl_upload) abort <= 1'b1;
          if (mem_sync) begin
            if (abort || !ioctl_upload) begin
              state      <= IDLE;
              mem_req    <= 1'b0;
              busy       <= 1'b0;
              pend_valid <= 1'b0;
            end else if (next_req) begin
              state      <= WAIT_SLOT;
              pend_valid <= 1'b0;
              mem_adr    <= next_adr;
`ifdef UPLOAD_PREFETCH_EN
              if (pf_run && (next_adr == mem_adr)) begin
                ioctl_din <= mem_data;
                mem_adr   <= mem_adr + AW'(1);
              end else begin
                pf_run    <= 1'b0;
              end
`endif
            end else begin
`ifdef UPLOAD_PREFETCH_EN
              if (pf_run) begin
                pf_data  <= mem_data;
                pf_tag   <= mem_adr;
                pf_valid <= 1'b1;
                state    <= IDLE;
                mem_req  <= 1'b0;
                busy     <= 1'b0;
              end else begin
                ioctl_din <= mem_data;
                mem_adr   <= mem_adr + AW'(1);
                pf_run    <= 1'b1;
                state     <= WAIT_SLOT;
              end
`else
              ioctl_din <= mem_data;
              state     <= IDLE;
              mem_req   <= 1'b0;
              busy      <= 1'b0;
`endif
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_upload_reader.sv
`default_nettype none
// ============================================================================
// tb_sdram_upload_reader : directed and random upload reads checked against a
// slot-counting model of the reader.  Rev 1.0
// ============================================================================
module tb_sdram_upload_reader;

  localparam logic [24:0] ROM_BASE   = 25'h080000;
  localparam logic [24:0] SWRAM_BASE = 25'h040000;

  logic        clk_48m = 1'b0;
  logic        reset = 1'b1;
  logic        mem_sync = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din, cmos_din, mem_data;
  logic [24:0] mem_adr;
  logic        mem_req, busy, rd_miss;

  logic [7:0]  cmos_mem [128];
  logic [24:0] slot_adr = '0;
  int          checks = 0;
  int          errors = 0;
  int          sync_per = 24;
  int          sync_cnt = 0;
  bit          sync_rand = 1'b0;
  bit          chk_en = 1'b0;

  // reference state
  logic [7:0]  m_din = 8'hFF;
  logic [24:0] m_adr = '0;
  logic [24:0] m_pend_adr = '0;
  bit          m_busy = 0, m_miss = 0, m_pend = 0, m_abort = 0, m_upl_d = 0;
  int          m_syncs = 0;

  sdram_upload_reader dut (
    .clk_48m      (clk_48m),
    .reset        (reset),
    .mem_sync     (mem_sync),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .cmos_din     (cmos_din),
    .mem_req      (mem_req),
    .mem_adr      (mem_adr),
    .mem_data     (mem_data),
    .busy         (busy),
    .rd_miss      (rd_miss)
  );

  always #5 clk_48m = ~clk_48m;

  function automatic logic [7:0] sdram_byte(input logic [24:0] a);
    if (a == 25'h080010) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ {a[24], 7'h2E};
  endfunction

  assign cmos_din = cmos_mem[ioctl_addr[6:0]];
  assign mem_data = sdram_byte(slot_adr);

  // SDRAM: a slot reads whatever address is on the bus at its opening mem_sync.
  always @(posedge clk_48m)
    if (mem_sync) slot_adr <= mem_req ? mem_adr : 25'($urandom);

  always @(posedge clk_48m) begin
    #1;
    if (sync_cnt == 0) begin
      mem_sync = 1'b1;
      sync_cnt = sync_rand ? int'($urandom_range(20, 8)) - 1 : sync_per - 1;
    end else begin
      mem_sync = 1'b0;
      sync_cnt = sync_cnt - 1;
    end
  end

  // Model: a fetch delivers on the second mem_sync after it starts.
  always @(posedge clk_48m) begin
    bit          ok, fe;
    logic [24:0] a;
    ok = ioctl_rd && ioctl_upload;
    fe = (ioctl_index == 8'h00) || (ioctl_index == 8'h01);
    a  = ((ioctl_index == 8'h01) ? SWRAM_BASE : ROM_BASE) + ioctl_addr;
    if (reset) begin
      m_din = 8'hFF; m_adr = '0; m_busy = 0; m_miss = 0;
      m_pend = 0; m_abort = 0; m_upl_d = 0; m_syncs = 0;
    end else begin
      if (ioctl_upload && !m_upl_d) m_miss = 0;
      m_upl_d = ioctl_upload;
      if (!ioctl_upload) m_pend = 0;
      if (!m_busy) begin
        if (ok) begin
          if (ioctl_index == 8'hFF) m_din = cmos_mem[ioctl_addr[6:0]];
          else if (fe) begin m_busy = 1; m_adr = a; m_syncs = 2; m_abort = 0; end
          else m_din = 8'hFF;
        end
      end else begin
        if (ok) begin
          m_miss = 1;
          if (fe) begin m_pend = 1; m_pend_adr = a; end
        end
        if (!ioctl_upload && m_syncs == 2) begin
          m_busy = 0;
        end else begin
          if (!ioctl_upload) m_abort = 1;
          if (mem_sync) begin
            m_syncs = m_syncs - 1;
            if (m_syncs == 0) begin
              if (m_abort) begin m_busy = 0; m_pend = 0; end
              else if (m_pend) begin m_adr = m_pend_adr; m_syncs = 2; m_pend = 0; end
              else begin m_din = sdram_byte(m_adr); m_busy = 0; end
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_48m) begin
    if (chk_en) begin
      check("din",     25'(ioctl_din), 25'(m_din));
      check("mem_req", 25'(mem_req),   25'(m_busy));
      check("busy",    25'(busy),      25'(m_busy));
      check("mem_adr", mem_adr,        m_adr);
      check("rd_miss", 25'(rd_miss),   25'(m_miss));
    end
  end

  task automatic tick();
    @(posedge clk_48m);
    #2;
  endtask

  task automatic do_rd(input logic [24:0] a);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd   = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 200 && busy; k++) tick();
    check("idle_bound", 25'(busy), 25'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_din"},     25'(ioctl_din), 25'(8'hFF));
    check({tag, "_mem_req"}, 25'(mem_req),   25'(0));
    check({tag, "_mem_adr"}, mem_adr,        25'(0));
    check({tag, "_busy"},    25'(busy),      25'(0));
    check({tag, "_rd_miss"}, 25'(rd_miss),   25'(0));
  endtask

  initial begin
    int n;
    int r;
    for (int i = 0; i < 128; i++) cmos_mem[i] = 8'($urandom);
    cmos_mem[7'h12] = 8'h3C;

    repeat (3) tick();
    chk_en = 1'b1;
    check_reset_values("rst");
    reset = 1'b0;
    ioctl_upload = 1'b1;
    ioctl_index  = 8'h00;
    tick();

    // ROM fetch with 24-clock slots
    do_rd(25'h00010);
    check("rom_adr", mem_adr, 25'h080010);
    check("rom_req", 25'(mem_req), 25'(1));
    n = 1;
    while (busy && n < 60) begin tick(); n++; end
    check("rom_latency_le_49", 25'(n <= 49), 25'(1));
    check("rom_din", 25'(ioctl_din), 25'(8'hA5));
    check("rom_req_done", 25'(mem_req), 25'(0));

    ioctl_index = 8'h01;
    do_rd(25'h1FFFF);
    check("swram_adr", mem_adr, 25'h05FFFF);
    wait_idle();

    // 25'h1FF80000 truncated to 25 bits is 25'h1F80000; plus ROM_BASE wraps to 0
    ioctl_index = 8'h00;
    do_rd(25'h1F80000);
    check("wrap_adr", mem_adr, 25'h0000000);
    wait_idle();

    ioctl_index = 8'hFF;
    do_rd(25'h12);
    check("cmos_din", 25'(ioctl_din), 25'(8'h3C));
    check("cmos_no_req", 25'(mem_req), 25'(0));

    ioctl_index = 8'h00;
    do_rd(25'h5);
    tick();
    tick();
    do_rd(25'h6);
    check("miss_set", 25'(rd_miss), 25'(1));
    wait_idle();
    check("queued_din", 25'(ioctl_din), 25'(8'h20));

    // upload dropped while the slot data is pending
    do_rd(25'h7);
    for (int k = 0; k < 40 && !mem_sync; k++) tick();
    tick();
    ioctl_upload = 1'b0;
    for (int k = 0; k < 30 && mem_req; k++) tick();
    check("abort_req", 25'(mem_req), 25'(0));
    check("abort_din", 25'(ioctl_din), 25'(8'h20));
    repeat (5) tick();
    ioctl_upload = 1'b1;
    tick();
    check("miss_clear", 25'(rd_miss), 25'(0));

    do_rd(25'h8);
    do_rd(25'h9);
    check("pre_reset_busy", 25'(busy), 25'(1));
    reset = 1'b1;
    tick();
    check_reset_values("midrst");
    reset = 1'b0;
    tick();

    sync_rand = 1'b1;
    for (int it = 0; it < 5000; it++) begin
      r = int'($urandom_range(199, 0));
      if (r < 16) begin
        ioctl_addr = (r < 3) ? 25'($urandom) : 25'($urandom_range(300, 0));
        ioctl_rd   = 1'b1;
      end else if (r == 16) begin
        ioctl_upload = 1'b0;
        for (int k = 0; k < 45; k++) begin
          ioctl_rd = ($urandom_range(9, 0) == 0);
          tick();
        end
        ioctl_rd = 1'b0;
        case ($urandom_range(3, 0))
          0: ioctl_index = 8'h00;
          1: ioctl_index = 8'h01;
          2: ioctl_index = 8'hFF;
          default: ioctl_index = 8'h05;
        endcase
        ioctl_upload = 1'b1;
      end else if (r == 17 && $urandom_range(9, 0) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      tick();
      ioctl_rd = 1'b0;
    end

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
